// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//
// Output-side collector for the systolic MAC array. Each array column emits
// partial sums skewed in time, qualified by its own valid bit. Every column
// owns a FIFO; a full-width row is released only when all columns hold at
// least one entry, so the skew is removed on the way to the SRAM writer.
//
// Parameters
//   col      number of array columns (lanes)
//   psum_bw  width of one partial sum, two's complement
//   depth    entries per column FIFO (power of two, >= 2)
//
// Ports (all synchronous to clk)
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   in        packed lanes, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr        per-column write strobe (array column valid bits)
//   rd        read request; pops one full row when o_valid is high
//   out       registered row output, same packing as in
//   out_vld   one-cycle pulse: out holds a newly popped row
//   o_valid   every column FIFO is non-empty
//   o_full    at least one column FIFO is full
//   overflow  sticky: a write was dropped because its FIFO was full
//
// Optional feature
//   PSUM_COLLECTOR_RELU_EN  when defined, each lane is clamped to zero if
//                           negative on the read path; FIFOs store raw data.
// ---------------------------------------------------------------------------
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_vld,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int W  = psum_bw * col;

  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  // Read-path lane transform.
`ifdef PSUM_COLLECTOR_RELU_EN
  function automatic logic [psum_bw-1:0] lane_fn(input logic [psum_bw-1:0] v);
    logic [psum_bw-1:0] r;
    if (v[psum_bw-1]) begin
      r = {psum_bw{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction
`else
  function automatic logic [psum_bw-1:0] lane_fn(input logic [psum_bw-1:0] v);
    return v;
  endfunction
`endif

  // Storage and pointers; the pointer MSB is the wrap bit.
  logic [psum_bw-1:0] mem_q  [col][depth];
  logic [PW-1:0]      wptr_q [col];
  logic [PW-1:0]      wptr_d [col];
  logic [PW-1:0]      rptr_q [col];
  logic [PW-1:0]      rptr_d [col];

  logic [W-1:0]   out_q;
  logic [W-1:0]   out_d;
  logic           out_vld_q;
  logic           out_vld_d;
  logic           overflow_q;
  logic           overflow_d;

  logic [col-1:0] empty_s;
  logic [col-1:0] full_s;
  logic [col-1:0] push_s;
  logic           rd_acc_s;
  logic           drop_s;
  logic [W-1:0]   head_s;

  // Per-column status flags, derived only from registered pointers.
  always_comb begin
    empty_s = {col{1'b0}};
    full_s  = {col{1'b0}};
    for (int c = 0; c < col; c++) begin
      empty_s[c] = (wptr_q[c] == rptr_q[c]);
      full_s[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                   (wptr_q[c][AW] != rptr_q[c][AW]);
    end
  end

  assign o_valid  = ~|empty_s;
  assign o_full   = |full_s;
  assign out      = out_q;
  assign out_vld  = out_vld_q;
  assign overflow = overflow_q;

  // Push/pop decisions, pointer next-state and the popped head row.
  always_comb begin
    rd_acc_s = rd & o_valid;
    push_s   = {col{1'b0}};
    head_s   = {W{1'b0}};
    for (int c = 0; c < col; c++) begin
      // A full FIFO still accepts a write when the same edge pops it:
      // the slot being freed is the one being written.
      push_s[c] = wr[c] & (~full_s[c] | rd_acc_s);
      if (push_s[c]) begin
        wptr_d[c] = wptr_q[c] + PTR_ONE;
      end else begin
        wptr_d[c] = wptr_q[c];
      end
      if (rd_acc_s) begin
        rptr_d[c] = rptr_q[c] + PTR_ONE;
      end else begin
        rptr_d[c] = rptr_q[c];
      end
      // Head is read from the registered RAM, so a same-cycle write is
      // never bypassed to the output.
      head_s[psum_bw*c +: psum_bw] = lane_fn(mem_q[c][rptr_q[c][AW-1:0]]);
    end
    drop_s = |(wr & ~push_s);
  end

  // Output and sticky-flag next-state.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = 1'b0;
    overflow_d = overflow_q | drop_s;
    if (rd_acc_s) begin
      out_d     = head_s;
      out_vld_d = 1'b1;
    end else begin
      out_d     = out_q;
      out_vld_d = 1'b0;
    end
  end

  // Pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= PTR_ZERO;
        rptr_q[c] <= PTR_ZERO;
      end
      out_q      <= {W{1'b0}};
      out_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO RAM write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        if (push_s[c]) begin
          mem_q[c][wptr_q[c][AW-1:0]] <= in[psum_bw*c +: psum_bw];
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int W   = COL * BW;

  logic           clk;
  logic           reset;
  logic [W-1:0]   din;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   dout;
  logic           out_vld;
  logic           o_valid;
  logic           o_full;
  logic           overflow;

  int pass_cnt;
  int total_cnt;

  psum_collector #(.col(COL), .psum_bw(BW), .depth(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .wr      (wr),
    .rd      (rd),
    .out     (dout),
    .out_vld (out_vld),
    .o_valid (o_valid),
    .o_full  (o_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   din;
    logic           e_valid;
    logic           e_full;
    logic           e_vld;
    logic [W-1:0]   e_out;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  // Distinct per-lane row: lane c = c*256 + r
  function automatic logic [W-1:0] mk(input int r);
    logic [W-1:0] row;
    for (int c = 0; c < COL; c++) row[BW*c +: BW] = 16'(c * 256 + r);
    return row;
  endfunction

  task automatic do_reset();
    reset = 1'b0; wr = 8'h00; rd = 1'b0; din = {W{1'b0}};
    tick(); tick();
    reset = 1'b1;
  endtask

  logic [W-1:0] skew_row;
  logic [W-1:0] relu_in;
  logic [W-1:0] relu_exp;
  logic [BW-1:0] neg_exp;
  logic valid_seen;
  int nexp;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b0; wr = 8'h00; rd = 1'b0; din = {W{1'b0}};

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_out", dout, {W{1'b0}});
    chk("rst_out_vld", W'(out_vld), W'(1'b0));
    chk("rst_o_valid", W'(o_valid), W'(1'b0));
    chk("rst_o_full", W'(o_full), W'(1'b0));
    chk("rst_overflow", W'(overflow), W'(1'b0));
    reset = 1'b1;

    // ---------------- table: skew, ignored rd, ReLU, push+pop ----------------
`ifdef PSUM_COLLECTOR_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFF6;
`endif
    for (int c = 0; c < COL; c++) begin
      skew_row[BW*c +: BW] = 16'(100 + c);
      relu_in[BW*c +: BW]  = (c % 2 == 0) ? 16'hFFF6 : 16'h000A;
      relu_exp[BW*c +: BW] = (c % 2 == 0) ? neg_exp : 16'h000A;
    end
    for (int k = 0; k < COL; k++) begin
      logic [W-1:0] row;
      row = rep(16'hDEAD);
      row[BW*k +: BW] = 16'(100 + k);
      tbl[k] = '{wr: 8'(1 << k), rd: 1'b0, din: row, e_valid: (k == COL - 1),
                 e_full: 1'b0, e_vld: 1'b0, e_out: {W{1'b0}}};
    end
    tbl[8]  = '{8'h00, 1'b1, rep(16'h0000), 1'b0, 1'b0, 1'b1, skew_row};
    tbl[9]  = '{8'h00, 1'b1, rep(16'h0000), 1'b0, 1'b0, 1'b0, skew_row};
    tbl[10] = '{8'hFF, 1'b0, relu_in,       1'b1, 1'b0, 1'b0, skew_row};
    tbl[11] = '{8'h00, 1'b1, rep(16'h0000), 1'b0, 1'b0, 1'b1, relu_exp};
    tbl[12] = '{8'h00, 1'b0, rep(16'h0000), 1'b0, 1'b0, 1'b0, relu_exp};
    tbl[13] = '{8'hFF, 1'b0, rep(16'h0001), 1'b1, 1'b0, 1'b0, relu_exp};
    tbl[14] = '{8'hFF, 1'b1, rep(16'h0002), 1'b1, 1'b0, 1'b1, rep(16'h0001)};
    tbl[15] = '{8'h00, 1'b1, rep(16'h0000), 1'b0, 1'b0, 1'b1, rep(16'h0002)};

    for (int i = 0; i < 16; i++) begin
      wr = tbl[i].wr; rd = tbl[i].rd; din = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_o_valid", i), W'(o_valid), W'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_o_full", i), W'(o_full), W'(tbl[i].e_full));
      chk($sformatf("tbl%0d_out_vld", i), W'(out_vld), W'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_out", i), dout, tbl[i].e_out);
    end
    wr = 8'h00; rd = 1'b0;

    // ---------------- overflow on column 0 ----------------
    do_reset();
    valid_seen = 1'b0;
    for (int i = 0; i < 65; i++) begin
      wr = 8'h01; din = {{(W-BW){1'b0}}, 16'(i)};
      tick();
      valid_seen = valid_seen | o_valid;
      if (i == 63) begin
        chk("ovf_full_at64", W'(o_full), W'(1'b1));
        chk("ovf_flag_at64", W'(overflow), W'(1'b0));
      end
      if (i == 64) begin
        chk("ovf_full_at65", W'(o_full), W'(1'b1));
        chk("ovf_flag_at65", W'(overflow), W'(1'b1));
      end
    end
    wr = 8'h00;
    tick(); tick(); tick();
    chk("ovf_sticky", W'(overflow), W'(1'b1));
    chk("ovf_no_valid", W'(valid_seen), W'(1'b0));

    // ---------------- reset mid-fill ----------------
    do_reset();
    chk("rst_clears_ovf", W'(overflow), W'(1'b0));
    for (int k = 0; k < 5; k++) begin
      wr = 8'hFF; din = rep(16'(16'h1000 + k));
      tick();
    end
    reset = 1'b0; wr = 8'hFF; rd = 1'b1; din = rep(16'hBEEF);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mid_rst_o_valid", W'(o_valid), W'(1'b0));
      chk("mid_rst_o_full", W'(o_full), W'(1'b0));
      chk("mid_rst_overflow", W'(overflow), W'(1'b0));
      chk("mid_rst_out", dout, {W{1'b0}});
      chk("mid_rst_out_vld", W'(out_vld), W'(1'b0));
    end
    reset = 1'b1; wr = 8'hFF; rd = 1'b0; din = rep(16'h2222);
    tick();
    chk("refill_o_valid", W'(o_valid), W'(1'b1));
    wr = 8'h00; rd = 1'b1;
    tick();
    chk("refill_out", dout, rep(16'h2222));
    chk("refill_out_vld", W'(out_vld), W'(1'b1));
    chk("refill_drained", W'(o_valid), W'(1'b0));
    rd = 1'b0;

    // ---------------- full with simultaneous pop ----------------
    do_reset();
    for (int r = 0; r < 64; r++) begin
      wr = 8'hFF; din = mk(r);
      tick();
    end
    chk("full_o_full", W'(o_full), W'(1'b1));
    chk("full_o_valid", W'(o_valid), W'(1'b1));
    wr = 8'hFF; rd = 1'b1; din = rep(16'h55AA);
    tick();
    chk("fullpop_out", dout, mk(0));
    chk("fullpop_out_vld", W'(out_vld), W'(1'b1));
    chk("fullpop_o_full", W'(o_full), W'(1'b1));
    chk("fullpop_overflow", W'(overflow), W'(1'b0));
    wr = 8'h00; rd = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("drain_row%0d", k), dout, (k < 64) ? mk(k) : rep(16'h55AA));
    end
    chk("drain_empty", W'(o_valid), W'(1'b0));
    rd = 1'b0;

    // ---------------- wrap-around streaming ----------------
    do_reset();
    nexp = 0;
    for (int i = 0; i < 205; i++) begin
      wr = (i < 200) ? 8'hFF : 8'h00;
      din = rep(16'(i));
      rd = 1'b1;
      tick();
      if (out_vld) begin
        chk($sformatf("stream_row%0d", nexp), dout, rep(16'(nexp)));
        nexp++;
      end
    end
    chk("stream_count", W'(nexp), W'(200));
    wr = 8'h00; rd = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
# psum_collector

Output-side collector for the systolic MAC array. It captures the skewed per-column partial sums that leave the bottom of the array, each qualified by its own column valid bit. It buffers them in one FIFO per column and re-aligns them into full-width rows. Rows are released to the downstream SRAM writer through a registered read port once every column holds at least one entry.

## Interface

**Parameters**
- `col`, 8: number of array columns (lanes)
- `psum_bw`, 16: width of one partial sum, two's complement
- `depth`, 64: entries per column FIFO; must be a power of two, at least 2

**Ports** (all synchronous to `clk`)
- `clk`, input, 1: clock; rising edge
- `reset`, input, 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `in`, input, `psum_bw*col`: column c occupies bits `[psum_bw*(c+1)-1 : psum_bw*c]`
- `wr`, input, `col`: per-column write strobe; driven directly by the array's column valid bits
- `rd`, input, 1: read request; pops one full row
- `out`, output, `psum_bw*col`: registered row output, same lane packing as `in`
- `out_vld`, output, 1: one-cycle pulse; `out` holds a newly popped row
- `o_valid`, output, 1: every column FIFO is non-empty, so a row is available
- `o_full`, output, 1: at least one column FIFO is full
- `overflow`, output, 1: sticky; a write was dropped

## Operation

**Storage**
- `col` independent FIFOs, each `depth` × `psum_bw`.
- Each FIFO has a write pointer and a read pointer of `log2(depth)+1` bits; the MSB is the wrap bit.
- Count per FIFO = `wptr - rptr`.
- Empty when the pointers are equal; full when the low bits match and the MSBs differ.

**Writes**
- When `wr[c]==1`, lane c of `in` is pushed into FIFO c.
- Columns write independently and may be written in any cycle, in any combination.
- A write to a full FIFO is accepted if the same cycle performs a pop (`rd` accepted). Otherwise the write is dropped, the pointers are unchanged, and `overflow` is set to 1.
- `overflow` clears only on reset.

**Reads**
- A read is accepted when `rd==1 && o_valid==1`.
- An accepted read pops the head entry of all columns simultaneously.
- The popped row is registered into `out`, and `out_vld` is set to 1 for the following cycle.
- `rd` while `o_valid==0` is ignored: no pop, `out` holds its value, `out_vld` stays 0. This is not an error.
- `out` holds the last popped row until the next accepted read.

**Flags**
- `o_valid` and `o_full` are combinational from the registered pointers only; they never depend on `wr` or `rd`.

**Arithmetic**
- Data passes through bit-exact, apart from the optional ReLU below.
- Pointers wrap modulo `2*depth`.

**Reset**
- All pointers go to 0.
- `out` = 0, `out_vld` = 0, `overflow` = 0, so `o_valid` = 0 and `o_full` = 0.
- Reset in mid-operation discards all buffered entries; FIFO RAM contents need not be cleared.
- Any `wr` or `rd` in the reset cycle is ignored.

## Timing

- A write at edge N is visible in the flags after edge N: `o_valid` can rise in the cycle after the last column's write.
- Read latency is 1: `rd` accepted at edge N gives `out`/`out_vld` valid after edge N, for exactly one cycle.
- The flags update after the same edge as the pop.
- Sustained throughput is one row per cycle once all columns are non-empty.
- Simultaneous push and pop on one column in the same cycle: the count is unchanged, and the popped entry is the old head, never the entry being written.
- With `depth`==1 effective occupancy, the just-written entry is never bypassed to `out` in the same cycle.

## Configuration

- Macro: `PSUM_COLLECTOR_RELU_EN`.
- **Defined:** each lane is clamped on the read path before `out` is registered. A negative value (MSB==1) becomes 0; a non-negative value passes unchanged. The FIFO contents are stored raw.
- **Undefined:** `out` is the raw stored value. No ReLU logic is synthesized.

## Test plan

- **Reset mid-fill:** write 5 entries to every column, then drive `reset=0` for 2 cycles with `wr`/`rd` active. Required: `o_valid=0`, `o_full=0`, `overflow=0`, `out=0`, `out_vld=0`, and the next read after refill returns only the new data.
- **Skewed alignment:** assert `wr[c]` at cycle c with lane value `100+c` (c=0..7). Required: `o_valid` rises only in the cycle after cycle 7. Then `rd=1` gives `out` lanes = 100..107 with `out_vld` for exactly 1 cycle one cycle later, and `o_valid` returns to 0.
- **Overflow:** 65 writes to column 0 only, no reads. Required: `o_full=1` after the 64th write; the 65th write is dropped; `overflow=1` and stays set; `o_valid=0` throughout.
- **Full with simultaneous pop:** fill all columns to 64, then assert `rd` and all `wr` together with value `0x55AA`. Required: the write is accepted, `o_full` stays 1, `overflow` stays 0, and `out` = the first-written row.
- **Wrap-around streaming:** 200 rows with lane value = row index, `rd` held high. Required: the `out` sequence is 0..199 in order, with no loss or duplication across pointer wraps.
- **ReLU:** lane value `16'hFFF6` (-10) and `16'h000A` → `out` = 0 and 10 with the macro defined; `FFF6` and 10 without it.
